// File: rtl/vga_pattern_engine_if.sv
// Pin bundle of the VGA pattern engine: pattern controls in, timing/pixel/frame status out.
// The slave side is the engine; the master side is whoever drives mode/fg_color and watches the pins.
interface vga_pattern_engine_if #(
   parameter int COORD_W = 10
) ();
   logic [1:0]         mode;
   logic [11:0]        fg_color;
   logic               hsync;
   logic               vsync;
   logic               de;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic [3:0]         vgaRed;
   logic [3:0]         vgaGreen;
   logic [3:0]         vgaBlue;
   logic               frame_start;
   logic [15:0]        frame_count;

   modport master (
      output mode, fg_color,
      input  hsync, vsync, de, x, y, vgaRed, vgaGreen, vgaBlue, frame_start, frame_count
   );

   modport slave (
      input  mode, fg_color,
      output hsync, vsync, de, x, y, vgaRed, vgaGreen, vgaBlue, frame_start, frame_count
   );
endinterface

// File: rtl/vga_pattern_engine.sv
// Parametrised VGA timing generator with a pixel clock-enable, a 2-stage registered pixel
// pipeline, four runtime-selectable test patterns, and frame-start / frame-count status.
module vga_pattern_engine #(
   parameter int CLK_DIV   = 4,
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int HS_POL    = 0,
   parameter int VS_POL    = 0,
   parameter int COORD_W   = 10,
   parameter int CHK_SHIFT = 5
) (
   input logic                 clk,
   input logic                 rst,
   vga_pattern_engine_if.slave vga
);
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int BAR_W    = H_ACTIVE / 8;
   localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic HS_ON  = 1'(HS_POL);
   localparam logic VS_ON  = 1'(VS_POL);

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic   de;
      logic   hs;
      logic   vs;
      coord_t x;
      coord_t y;
   } timing_t;

   localparam timing_t TIMING_RST = '{de: 1'b0, hs: ~HS_ON, vs: ~VS_ON, x: '0, y: '0};

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   coord_t           hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic             wrap0_q, wrap0_d;
   logic [1:0]       mode_q, mode_d;
   timing_t          s1_q, s1_d, s2_q, s2_d;
   logic [2:0]       bar1_q, bar1_d;
   coord_t           bar_pos1_q, bar_pos1_d;
   logic             sof1_q, sof1_d;
   logic [11:0]      rgb_q, rgb_d;
   logic             frame_start_q, frame_start_d;
   logic [15:0]      frame_count_q, frame_count_d;

   logic        pix_ce, h_last, v_last;
   logic [15:0] fc_next;
   logic [11:0] pattern_rgb;

   assign pix_ce  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
   assign h_last  = (hcnt_q == coord_t'(H_TOTAL - 1));
   assign v_last  = (vcnt_q == coord_t'(V_TOTAL - 1));
   // The gradient's blue channel shows the count of the frame being output, including its first pixel.
   assign fc_next = sof1_q ? frame_count_q + 16'd1 : frame_count_q;

   always_comb begin
      pattern_rgb = 12'h000;
      unique case (mode_q)
         2'd0: pattern_rgb = vga.fg_color;
         2'd1: begin
            unique case (bar1_q)
               3'd0: pattern_rgb = 12'hFFF;
               3'd1: pattern_rgb = 12'hFF0;
               3'd2: pattern_rgb = 12'h0FF;
               3'd3: pattern_rgb = 12'h0F0;
               3'd4: pattern_rgb = 12'hF0F;
               3'd5: pattern_rgb = 12'hF00;
               3'd6: pattern_rgb = 12'h00F;
               3'd7: pattern_rgb = 12'h000;
            endcase
         end
         2'd2: pattern_rgb = (s1_q.x[CHK_SHIFT] ^ s1_q.y[CHK_SHIFT]) ? 12'h000 : vga.fg_color;
         2'd3: pattern_rgb = {s1_q.x[9:6], s1_q.y[8:5], fc_next[3:0]};
      endcase
   end

   // NOTE: every _d starts from its _q (or a pulse default), so no path through this block can infer a latch.
   always_comb begin
      div_cnt_d     = pix_ce ? '0 : div_cnt_q + 1'b1;
      hcnt_d        = hcnt_q;
      vcnt_d        = vcnt_q;
      wrap0_d       = wrap0_q;
      mode_d        = mode_q;
      s1_d          = s1_q;
      s2_d          = s2_q;
      bar1_d        = bar1_q;
      bar_pos1_d    = bar_pos1_q;
      sof1_d        = sof1_q;
      rgb_d         = rgb_q;
      frame_start_d = 1'b0;
      frame_count_d = frame_count_q;

      if (pix_ce) begin
         hcnt_d  = h_last ? '0 : hcnt_q + 1'b1;
         if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
         wrap0_d = h_last && v_last;
         if (hcnt_q == '0 && vcnt_q == '0) mode_d = vga.mode;

         s1_d.de = (hcnt_q < coord_t'(H_ACTIVE)) && (vcnt_q < coord_t'(V_ACTIVE));
         s1_d.hs = (hcnt_q >= coord_t'(HS_START) && hcnt_q < coord_t'(HS_START + H_SYNC)) ? HS_ON : ~HS_ON;
         s1_d.vs = (vcnt_q >= coord_t'(VS_START) && vcnt_q < coord_t'(VS_START + V_SYNC)) ? VS_ON : ~VS_ON;
         s1_d.x  = hcnt_q;
         s1_d.y  = vcnt_q;
         sof1_d  = wrap0_q;

         // Bar index follows x1 by counting pixels within the current bar rather than dividing.
         if (hcnt_q == '0) begin
            bar1_d     = '0;
            bar_pos1_d = '0;
         end else if (bar_pos1_q == coord_t'(BAR_W - 1)) begin
            bar1_d     = bar1_q + 3'd1;
            bar_pos1_d = '0;
         end else begin
            bar_pos1_d = bar_pos1_q + 1'b1;
         end

         s2_d          = s1_q;
         rgb_d         = s1_q.de ? pattern_rgb : 12'h000;
         frame_start_d = sof1_q;
         frame_count_d = fc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q     <= '0;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         wrap0_q       <= 1'b0;
         mode_q        <= 2'd0;
         s1_q          <= TIMING_RST;
         s2_q          <= TIMING_RST;
         bar1_q        <= '0;
         bar_pos1_q    <= '0;
         sof1_q        <= 1'b0;
         rgb_q         <= 12'h000;
         frame_start_q <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         // NOTE: non-blocking updates let every flop see the pre-edge value of its neighbours.
         div_cnt_q     <= div_cnt_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         wrap0_q       <= wrap0_d;
         mode_q        <= mode_d;
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         bar1_q        <= bar1_d;
         bar_pos1_q    <= bar_pos1_d;
         sof1_q        <= sof1_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign vga.hsync       = s2_q.hs;
   assign vga.vsync       = s2_q.vs;
   assign vga.de          = s2_q.de;
   assign vga.x           = s2_q.x;
   assign vga.y           = s2_q.y;
   assign vga.vgaRed      = rgb_q[11:8];
   assign vga.vgaGreen    = rgb_q[7:4];
   assign vga.vgaBlue     = rgb_q[3:0];
   assign vga.frame_start = frame_start_q;
   assign vga.frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_pattern_engine.sv
// Self-checking bench for vga_pattern_engine on a shrunk raster: every clock is compared against a
// reference model that derives each pin from the number of pixel periods elapsed since reset.
module tb_vga_pattern_engine;
   localparam int CLK_DIV   = 3;
   localparam int H_ACTIVE  = 80;
   localparam int H_FP      = 4;
   localparam int H_SYNC    = 6;
   localparam int H_BP      = 6;
   localparam int V_ACTIVE  = 36;
   localparam int V_FP      = 2;
   localparam int V_SYNC    = 3;
   localparam int V_BP      = 3;
   localparam int HS_POL    = 1;
   localparam int VS_POL    = 0;
   localparam int COORD_W   = 10;
   localparam int CHK_SHIFT = 3;

   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FRAME_PIX = H_TOTAL * V_TOTAL;
   localparam int FRAME_CLK = FRAME_PIX * CLK_DIV;
   localparam int MAX_ERR   = 30;

   typedef struct {
      logic        hs;
      logic        vs;
      logic        de;
      int          x;
      int          y;
      logic [11:0] rgb;
      int          fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_pattern_engine_if #(.COORD_W(COORD_W)) vga ();

   vga_pattern_engine #(
      .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(HS_POL), .VS_POL(VS_POL), .COORD_W(COORD_W), .CHK_SHIFT(CHK_SHIFT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vga(vga)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   bit          abort    = 1'b0;
   int          clks;            // clocks since reset release
   int          pix;             // pixel periods since reset release
   logic [1:0]  frame_mode [0:15];
   logic [11:0] bar_lut    [0:7];
   exp_t        cur;
   int          last_fs;
   bit          first_fs_pending;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (clk %0d after reset, t=%0t)",
                  tag, actual, expected, clks, $time);
         if (n_errors >= MAX_ERR) abort = 1'b1;
      end
   endtask

   function automatic logic [11:0] pattern(input int h, input int v, input logic [1:0] mode,
                                           input logic [11:0] fg, input int frame);
      case (mode)
         2'd0:    return fg;
         2'd1:    return bar_lut[h / (H_ACTIVE / 8)];
         2'd2:    return (((h >> CHK_SHIFT) ^ (v >> CHK_SHIFT)) & 1) != 0 ? 12'h000 : fg;
         default: return {4'((h >> 6) & 15), 4'((v >> 5) & 15), 4'(frame & 15)};
      endcase
   endfunction

   // Pins after the n-th pixel period show raster position n-2 (two pipeline stages);
   // before that they hold reset values.
   function automatic exp_t model_out(input int n, input logic [11:0] fg);
      exp_t e;
      int p, h, v, f;
      e = '{hs: ~1'(HS_POL), vs: ~1'(VS_POL), de: 1'b0, x: 0, y: 0, rgb: 12'h000, fc: 0};
      if (n >= 2) begin
         p    = n - 2;
         h    = p % H_TOTAL;
         v    = (p / H_TOTAL) % V_TOTAL;
         f    = p / FRAME_PIX;
         e.x  = h;
         e.y  = v;
         e.de = (h < H_ACTIVE) && (v < V_ACTIVE);
         e.hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? 1'(HS_POL) : ~1'(HS_POL);
         e.vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? 1'(VS_POL) : ~1'(VS_POL);
         e.fc = f % 65536;
         e.rgb = e.de ? pattern(h, v, frame_mode[f % 16], fg, f) : 12'h000;
      end
      return e;
   endfunction

   // One clock: advance the model with the inputs seen at the edge, then compare all pins 1 time unit later.
   task automatic cycle();
      logic [11:0] fg_s;
      logic [1:0]  mode_s;
      logic        fs_exp;
      @(posedge clk);
      fg_s   = vga.fg_color;
      mode_s = vga.mode;
      fs_exp = 1'b0;
      if (rst) begin
         clks             = 0;
         pix              = 0;
         first_fs_pending = 1'b1;
         cur              = model_out(0, fg_s);
      end else begin
         clks++;
         if (clks % CLK_DIV == 0) begin
            pix++;
            // Pattern mode is taken at the pixel period where the raster counter sits at (0,0).
            if ((pix - 1) % FRAME_PIX == 0) frame_mode[((pix - 1) / FRAME_PIX) % 16] = mode_s;
            cur    = model_out(pix, fg_s);
            fs_exp = (pix > 2) && ((pix - 2) % FRAME_PIX == 0);
         end
      end
      #1;
      check("hsync",       32'(vga.hsync),       32'(cur.hs));
      check("vsync",       32'(vga.vsync),       32'(cur.vs));
      check("de",          32'(vga.de),          32'(cur.de));
      check("x",           32'(vga.x),           32'(cur.x));
      check("y",           32'(vga.y),           32'(cur.y));
      check("rgb",         32'({vga.vgaRed, vga.vgaGreen, vga.vgaBlue}), 32'(cur.rgb));
      check("frame_count", 32'(vga.frame_count), 32'(cur.fc));
      check("frame_start", 32'(vga.frame_start), 32'(fs_exp));
      if (vga.frame_start === 1'b1) begin
         if (first_fs_pending) check("first_frame_start_latency", 32'(clks), 32'((FRAME_PIX + 2) * CLK_DIV));
         else                  check("frame_start_period", 32'(clks - last_fs), 32'(FRAME_CLK));
         first_fs_pending = 1'b0;
         last_fs          = clks;
      end
   endtask

   initial begin
      bar_lut = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
      foreach (frame_mode[i]) frame_mode[i] = 2'd0;
      clks = 0;
      pix  = 0;
      last_fs = 0;
      first_fs_pending = 1'b1;
      vga.mode     = 2'd0;
      vga.fg_color = 12'h0F0;
      rst          = 1'b1;
      repeat (3) cycle();
      rst = 1'b0;

      // Frames 0..3 cycle through modes 0,1,2,3; an extra random mode write earlier in each
      // frame must be ignored because only the value present at the frame boundary counts.
      for (int i = 0; i < 4 * FRAME_CLK + FRAME_CLK / 2 && !abort; i++) begin
         cycle();
         if (clks % FRAME_CLK == FRAME_CLK / 4) vga.mode = 2'($urandom);
         if (clks % FRAME_CLK == FRAME_CLK / 2) vga.mode = 2'((clks / FRAME_CLK + 1) % 4);
         if ($urandom_range(0, 299) == 0) vga.fg_color = 12'($urandom);
      end

      // One-clock reset in the middle of a frame, then one full frame plus margin.
      if (!abort) begin
         repeat ($urandom_range(0, 40)) cycle();
         rst = 1'b1;
         cycle();
         rst = 1'b0;
         vga.mode = 2'd2;
         for (int i = 0; i < FRAME_CLK + 30 * CLK_DIV && !abort; i++) begin
            cycle();
            if ($urandom_range(0, 299) == 0) vga.fg_color = 12'($urandom);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
